// File: rtl/lsu_load_store_unit.sv
// lsu_load_store_unit: memory-stage load/store unit for the miniRV core.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// H/W accesses are flagged on lsu_misalign and skip the bus. When it is not
// defined, they are silently aligned.
// Handshake: in REQ, dmem_req is high and addr/we/wdata/wstrb are held stable
// until a cycle with dmem_gnt=1. The unit then waits in WAIT for exactly one
// dmem_rvalid, which acks both reads and writes. dmem_rvalid is ignored in
// every other state.
module lsu_load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              lsu_stall,
    output logic [31:0]       mem_rdata,
    output logic              rdata_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              lsu_misalign,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic              memop, accept, is_b, is_h;
    logic [3:0]        strb_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;

    // funct3[1:0]: 00 byte, 01 half, anything else (incl. illegal codes) word.
    assign memop  = ex_mem_read | ex_mem_write;
    assign accept = (state_q == IDLE) & ex_valid & memop;
    assign is_b   = (ex_funct3[1:0] == 2'b00);
    assign is_h   = (ex_funct3[1:0] == 2'b01);
    assign addr_d = {ex_addr[ADDR_W-1:2], 2'b00};
    assign dbg_state = state_q;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned, mis_q;
    assign misaligned   = (is_h & ex_addr[0]) | (~is_b & ~is_h & (ex_addr[1:0] != 2'b00));
    assign lsu_misalign = (state_q == DONE) & mis_q;
`endif

    // Store lane encoding: byte enables and lane-replicated data; reads get no strobes.
    always_comb begin
        strb_d  = 4'b0000;
        wdata_d = ex_wdata;
        if (ex_mem_write) begin
            if (is_b) begin
                strb_d  = 4'b0001 << ex_addr[1:0];
                wdata_d = {4{ex_wdata[7:0]}};
            end else if (is_h) begin
                strb_d  = 4'b0011 << {ex_addr[1], 1'b0};
                wdata_d = {2{ex_wdata[15:0]}};
            end else begin
                strb_d  = 4'b1111;
            end
        end
    end

    // Load extraction: pick byte lane a or halfword lane a[1], then extend.
    always_comb begin
        byte_sel = 8'(dmem_rdata >> {lane_q, 3'b000});
        half_sel = 16'(dmem_rdata >> {lane_q[1], 4'b0000});
        case (f3_q[1:0])
            2'b00:   load_val = f3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = f3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = misaligned ? DONE : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ:     if (dmem_gnt) state_d = WAIT;
            WAIT:    if (dmem_rvalid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        lsu_stall   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rdata_valid = 1'b0;
        case (state_q)
            IDLE: lsu_stall = ex_valid & memop;
            REQ: begin
                lsu_stall = 1'b1;
                dmem_req  = 1'b1;
                dmem_we   = we_q;
            end
            WAIT:    lsu_stall = 1'b1;
            default: rdata_valid = ~we_q;
        endcase
    end

    // Operation latch on accept; load result captured on the response edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            lane_q     <= 2'b00;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            mem_rdata  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                we_q       <= ex_mem_write;
                f3_q       <= ex_funct3;
                lane_q     <= ex_addr[1:0];
                dmem_addr  <= addr_d;
                dmem_wdata <= wdata_d;
                dmem_wstrb <= strb_d;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q      <= misaligned;
                if (misaligned & ~ex_mem_write) mem_rdata <= '0;
`endif
            end
            if ((state_q == WAIT) && dmem_rvalid && !we_q) mem_rdata <= load_val;
        end
    end

endmodule
